// File: rtl/tiny_alu_pkg.sv
// rtl/tiny_alu_pkg.sv - shared command, ALU op, flag index and state definitions for tiny_alu_seq
package tiny_alu_pkg;

    typedef enum logic [2:0] {
        CMD_ADD8  = 3'b000,
        CMD_SUB8  = 3'b001,
        CMD_AND8  = 3'b010,
        CMD_OR8   = 3'b011,
        CMD_ADD16 = 3'b100,
        CMD_SUB16 = 3'b101,
        CMD_CMP8  = 3'b110,
        CMD_RSVD  = 3'b111
    } cmd_op_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_O = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_RSP  = 3'd4
    } state_e;

    // ALU op used for the LO and HI passes of a command
    function automatic logic [1:0] alu_op_of(input cmd_op_e op);
        case (op)
            CMD_SUB8, CMD_SUB16, CMD_CMP8: alu_op_of = ALU_SUB;
            CMD_AND8:                      alu_op_of = ALU_AND;
            CMD_OR8:                       alu_op_of = ALU_OR;
            default:                       alu_op_of = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/tiny_alu.sv
// rtl/tiny_alu.sv - 8-bit ALU with {n,z,c,o} flags; c on subtract means no borrow
module tiny_alu
    import tiny_alu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [1:0] alu_op_i,
    output logic [7:0] res_o,
    output logic [3:0] flags_o
);

    logic [8:0] sum;
    logic       c;
    logic       o;

    always_comb begin
        sum = '0;
        c   = 1'b0;
        o   = 1'b0;
        case (alu_op_i)
            ALU_ADD: begin
                sum = {1'b0, a_i} + {1'b0, b_i};
                c   = sum[8];
                o   = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
            end
            ALU_SUB: begin
                sum = {1'b0, a_i} - {1'b0, b_i};
                c   = ~sum[8];
                o   = (a_i[7] != b_i[7]) && (sum[7] != a_i[7]);
            end
            ALU_AND: sum = {1'b0, a_i & b_i};
            default: sum = {1'b0, a_i | b_i};
        endcase
        res_o           = sum[7:0];
        flags_o         = '0;
        flags_o[FLAG_N] = sum[7];
        flags_o[FLAG_Z] = (sum[7:0] == 8'h00);
        flags_o[FLAG_C] = c;
        flags_o[FLAG_O] = o;
    end

endmodule

// File: rtl/tiny_alu_flag16.sv
// rtl/tiny_alu_flag16.sv - combinational {n,z,c,o} for a 16-bit result assembled from byte passes
module tiny_alu_flag16
    import tiny_alu_pkg::*;
(
    input  logic        a_msb,
    input  logic        b_msb,
    input  logic [15:0] res,
    input  logic        c_hi,
    input  logic        c_fix,
    input  logic        is_sub,
    output logic [3:0]  flags
);

    logic c;
    logic o;

    always_comb begin
        // carry out of the 16-bit op is carry/no-borrow of the high byte and its fix-up combined
        c = is_sub ? (c_hi & c_fix) : (c_hi | c_fix);
        o = is_sub ? ((a_msb != b_msb) && (res[15] != a_msb))
                   : ((a_msb == b_msb) && (res[15] != a_msb));
        flags         = '0;
        flags[FLAG_N] = res[15];
        flags[FLAG_Z] = (res == 16'h0000);
        flags[FLAG_C] = c;
        flags[FLAG_O] = o;
    end

endmodule

// File: rtl/tiny_alu_seq.sv
// rtl/tiny_alu_seq.sv - command sequencer running 8/16-bit ops as 1 or 3 passes of tiny_alu
// Optional TINY_ALU_SEQ_STATS_EN adds op_count_o, a saturating count of completed responses.
module tiny_alu_seq
    import tiny_alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [2:0]  cmd_op_i,
    input  logic [15:0] cmd_a_i,
    input  logic [15:0] cmd_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_res_o,
    output logic [3:0]  rsp_flags_o,
`ifdef TINY_ALU_SEQ_STATS_EN
    output logic [15:0] op_count_o,
`endif
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [1:0]  alu_op_o,
    input  logic [7:0]  alu_res_i,
    input  logic [3:0]  alu_flags_i
);

    state_e      state_q, state_d;
    cmd_op_e     op_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  lo_q, h_q;
    logic        c_lo_q, c_hi_q;
    logic [15:0] res_q;
    logic [3:0]  flags_q;
    logic [3:0]  flags16;
    logic        is16;
    logic        is_sub16;

    assign is16     = (op_q == CMD_ADD16) || (op_q == CMD_SUB16);
    assign is_sub16 = (op_q == CMD_SUB16);

    tiny_alu_flag16 u_flag16 (
        .a_msb  (a_q[15]),
        .b_msb  (b_q[15]),
        .res    ({alu_res_i, lo_q}),
        .c_hi   (c_hi_q),
        .c_fix  (alu_flags_i[FLAG_C]),
        .is_sub (is_sub16),
        .flags  (flags16)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        alu_a_o     = '0;
        alu_b_o     = '0;
        alu_op_o    = ALU_ADD;
        case (state_q)
            ST_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) begin
                    state_d = (cmd_op_i == CMD_RSVD) ? ST_RSP : ST_LO;
                end
            end
            ST_LO: begin
                alu_a_o  = a_q[7:0];
                alu_b_o  = b_q[7:0];
                alu_op_o = alu_op_of(op_q);
                state_d  = is16 ? ST_HI : ST_RSP;
            end
            ST_HI: begin
                alu_a_o  = a_q[15:8];
                alu_b_o  = b_q[15:8];
                alu_op_o = alu_op_of(op_q);
                state_d  = ST_FIX;
            end
            ST_FIX: begin
                // fold the low-byte carry (or borrow) into the high byte
                alu_a_o  = h_q;
                alu_b_o  = {7'b0, is_sub16 ? ~c_lo_q : c_lo_q};
                alu_op_o = is_sub16 ? ALU_SUB : ALU_ADD;
                state_d  = ST_RSP;
            end
            ST_RSP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q    <= CMD_ADD8;
            a_q     <= '0;
            b_q     <= '0;
            lo_q    <= '0;
            h_q     <= '0;
            c_lo_q  <= 1'b0;
            c_hi_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= cmd_op_e'(cmd_op_i);
                        a_q     <= cmd_a_i;
                        b_q     <= cmd_b_i;
                        res_q   <= '0;
                        flags_q <= '0;
                    end
                end
                ST_LO: begin
                    if (is16) begin
                        lo_q   <= alu_res_i;
                        c_lo_q <= alu_flags_i[FLAG_C];
                    end else begin
                        res_q   <= (op_q == CMD_CMP8) ? 16'h0000 : {8'h00, alu_res_i};
                        flags_q <= alu_flags_i;
                    end
                end
                ST_HI: begin
                    h_q    <= alu_res_i;
                    c_hi_q <= alu_flags_i[FLAG_C];
                end
                ST_FIX: begin
                    res_q   <= {alu_res_i, lo_q};
                    flags_q <= flags16;
                end
                default: ;
            endcase
        end
    end

    assign rsp_res_o   = (state_q == ST_RSP) ? res_q : 16'h0000;
    assign rsp_flags_o = (state_q == ST_RSP) ? flags_q : 4'h0;

`ifdef TINY_ALU_SEQ_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_count_q <= '0;
        end else if (rsp_valid_o && rsp_ready_i && (op_count_q != 16'hFFFF)) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count_o = op_count_q;
`endif

endmodule

// File: tb/tb_tiny_alu_seq.sv
// tb/tb_tiny_alu_seq.sv - self-checking bench for tiny_alu_seq wired to tiny_alu
module tb_tiny_alu_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i = '0;
    logic [15:0] cmd_a_i = '0;
    logic [15:0] cmd_b_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [15:0] rsp_res_o;
    logic [3:0]  rsp_flags_o;
    logic [7:0]  alu_a_o, alu_b_o, alu_res_i;
    logic [1:0]  alu_op_o;
    logic [3:0]  alu_flags_i;
`ifdef TINY_ALU_SEQ_STATS_EN
    logic [15:0] op_count_o;
`endif

    int checks = 0;
    int failures = 0;
    int rdy_mode = 0;

    // model state owned by the compare process
    bit          busy = 0;
    bit          seen = 0;
    logic [15:0] exp_res;
    logic [3:0]  exp_fl;
    int          exp_lat;
    int          acc_cyc;
    int          cyc = 0;
    int          mcnt = 0;

    tiny_alu_seq dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_op_i    (cmd_op_i),
        .cmd_a_i     (cmd_a_i),
        .cmd_b_i     (cmd_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_res_o   (rsp_res_o),
        .rsp_flags_o (rsp_flags_o),
`ifdef TINY_ALU_SEQ_STATS_EN
        .op_count_o  (op_count_o),
`endif
        .alu_a_o     (alu_a_o),
        .alu_b_o     (alu_b_o),
        .alu_op_o    (alu_op_o),
        .alu_res_i   (alu_res_i),
        .alu_flags_i (alu_flags_i)
    );

    tiny_alu u_alu (
        .a_i      (alu_a_o),
        .b_i      (alu_b_o),
        .alu_op_i (alu_op_o),
        .res_o    (alu_res_i),
        .flags_o  (alu_flags_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // result, flags and latency straight from the arithmetic meaning of each op
    function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic [3:0] fl, output int lat);
        int ua, ub, sa, sb, u, s;
        bit c, wide;
        logic [15:0] r;
        c = 0; s = 0; u = 0; wide = 0;
        ua = int'(a[7:0]); ub = int'(b[7:0]);
        sa = int'($signed(a[7:0])); sb = int'($signed(b[7:0]));
        case (op)
            3'd0: begin u = ua + ub; c = (u > 255); s = sa + sb; end
            3'd1, 3'd6: begin u = ua - ub; c = (ua >= ub); s = sa - sb; end
            3'd2: u = ua & ub;
            3'd3: u = ua | ub;
            3'd4, 3'd5: begin
                wide = 1;
                ua = int'(a); ub = int'(b);
                sa = int'($signed(a)); sb = int'($signed(b));
                if (op == 3'd4) begin u = ua + ub; c = (u > 65535); s = sa + sb; end
                else begin u = ua - ub; c = (ua >= ub); s = sa - sb; end
            end
            default: ;
        endcase
        if (op == 3'd7) begin
            res = 16'h0000; fl = 4'h0; lat = 1;
        end else if (wide) begin
            r = u[15:0];
            res = r;
            fl = {r[15], r == 16'h0000, c, (s > 32767) || (s < -32768)};
            lat = 4;
        end else begin
            r = {8'h00, u[7:0]};
            res = (op == 3'd6) ? 16'h0000 : r;
            fl = {r[7], r[7:0] == 8'h00, c, (s > 127) || (s < -128)};
            lat = 2;
        end
    endfunction

    always @(posedge clk_i) begin
        #1;
        case (rdy_mode)
            0: rsp_ready_i = 1'b1;
            1: rsp_ready_i = 1'($urandom_range(0, 1));
            default: rsp_ready_i = 1'b0;
        endcase
    end

    always @(negedge clk_i) begin : compare
        if (!rst_ni) begin
            busy = 0;
            mcnt = 0;
        end else begin
            cyc++;
            chk("cmd_ready", cmd_ready_o, !busy);
            if (!busy) begin
                chk("rsp_valid_idle", rsp_valid_o, 0);
                chk("alu_ports_idle", {alu_a_o, alu_b_o, alu_op_o}, 0);
            end else if (rsp_valid_o) begin
                chk("rsp_res", rsp_res_o, exp_res);
                chk("rsp_flags", rsp_flags_o, exp_fl);
                if (!seen) begin
                    chk("latency", cyc - acc_cyc, exp_lat);
                    seen = 1;
                end
            end else if (seen || (cyc - acc_cyc >= exp_lat)) begin
                chk("rsp_valid_due", rsp_valid_o, 1);
            end
`ifdef TINY_ALU_SEQ_STATS_EN
            chk("op_count", op_count_o, mcnt);
`endif
            if (busy && rsp_valid_o && rsp_ready_i) begin
                busy = 0;
                if (mcnt != 65535) mcnt++;
            end else if (!busy && cmd_valid_i && cmd_ready_o) begin
                model(cmd_op_i, cmd_a_i, cmd_b_i, exp_res, exp_fl, exp_lat);
                busy = 1;
                seen = 0;
                acc_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int k;
        cmd_op_i = op; cmd_a_i = a; cmd_b_i = b; cmd_valid_i = 1'b1;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!cmd_ready_o && k < 100);
        if (!cmd_ready_o) chk("send_timeout", cmd_ready_o, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        cmd_op_i = 3'($urandom); cmd_a_i = 16'($urandom); cmd_b_i = 16'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin @(negedge clk_i); k++; end while (busy && k < 200);
        if (busy) chk("idle_timeout", busy, 0);
    endtask

    logic [2:0]  t_op [9] = '{3'd0, 3'd1, 3'd6, 3'd4, 3'd4, 3'd5, 3'd5, 3'd2, 3'd7};
    logic [15:0] t_a  [9] = '{16'h007F, 16'h0005, 16'h0005, 16'h00FF, 16'h7FFF, 16'h0000, 16'h1234, 16'h00F0, 16'h5555};
    logic [15:0] t_b  [9] = '{16'h0001, 16'h0005, 16'h0005, 16'h0001, 16'h0001, 16'h0001, 16'h1234, 16'h003C, 16'hAAAA};
    logic [15:0] t_res[9] = '{16'h0080, 16'h0000, 16'h0000, 16'h0100, 16'h8000, 16'hFFFF, 16'h0000, 16'h0030, 16'h0000};
    logic [3:0]  t_fl [9] = '{4'b1001, 4'b0110, 4'b0110, 4'b0000, 4'b1001, 4'b1000, 4'b0110, 4'b0000, 4'b0000};
    int          t_lat[9] = '{2, 2, 2, 4, 4, 4, 4, 2, 1};

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] mr;
        logic [3:0]  mf;
        int          ml;
        int          k;
        logic [15:0] ra, rb;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_cmd_ready", cmd_ready_o, 1);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp", {rsp_res_o, rsp_flags_o}, 0);
        chk("reset_alu", {alu_a_o, alu_b_o, alu_op_o}, 0);
`ifdef TINY_ALU_SEQ_STATS_EN
        chk("reset_op_count", op_count_o, 0);
`endif
        for (int i = 0; i < 9; i++) begin
            model(t_op[i], t_a[i], t_b[i], mr, mf, ml);
            chk($sformatf("model_res_%0d", i), mr, t_res[i]);
            chk($sformatf("model_flags_%0d", i), mf, t_fl[i]);
            chk($sformatf("model_lat_%0d", i), ml, t_lat[i]);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        rdy_mode = 0;
        for (int i = 0; i < 9; i++) begin
            send(t_op[i], t_a[i], t_b[i]);
            wait_idle();
            @(posedge clk_i); #1;
        end

        // backpressure: hold the AND8 response while a second command waits
        rdy_mode = 2;
        @(posedge clk_i); #1;
        send(3'd2, 16'h00F0, 16'h003C);
        k = 0;
        do begin @(negedge clk_i); k++; end while (!rsp_valid_o && k < 20);
        chk("bp_rsp_seen", rsp_valid_o, 1);
        cmd_op_i = 3'd0; cmd_a_i = 16'h007F; cmd_b_i = 16'h0001; cmd_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_hold_res", rsp_res_o, 16'h0030);
            chk("bp_hold_valid", rsp_valid_o, 1);
            chk("bp_cmd_ready", cmd_ready_o, 0);
        end
        rdy_mode = 0;
        k = 0;
        do begin @(negedge clk_i); k++; end while (!cmd_ready_o && k < 20);
        chk("bp_second_accept", cmd_ready_o, 1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        wait_idle();
        @(posedge clk_i); #1;

        // reset while the ADD16 high-byte pass is on the ALU
        send(3'd4, 16'h1234, 16'h4321);
        @(posedge clk_i); #1;
        chk("hi_alu_a", alu_a_o, 8'h12);
        chk("hi_alu_b", alu_b_o, 8'h43);
        rst_ni = 1'b0;
        #1;
        chk("midrst_ready", cmd_ready_o, 1);
        chk("midrst_valid", rsp_valid_o, 0);
        chk("midrst_alu", {alu_a_o, alu_b_o, alu_op_o}, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (6) begin
            @(negedge clk_i);
            chk("midrst_no_rsp", rsp_valid_o, 0);
        end
        @(posedge clk_i); #1;

        // randomized commands with random response backpressure
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                2: ra = 16'h7FFF;
                3: ra = 16'h8000;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            send(3'($urandom_range(0, 7)), ra, rb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
        end
        wait_idle();
        repeat (3) @(posedge clk_i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tiny_alu_seq.md
Name: tiny_alu_seq

Overview:
- Command sequencer that sits in front of tiny_alu as its initiator. It drives the ALU operand/op ports and consumes the ALU result and flags {n,z,c,o}.
- Accepts 8- and 16-bit commands over a valid/ready handshake and runs 1 or 3 ALU passes per command.
- Returns a 16-bit result plus flags over a valid/ready response channel, with backpressure.

Parameters:
- none; widths fixed: ALU 8 bit, command operands 16 bit

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_op_i  in  3  000 ADD8, 001 SUB8, 010 AND8, 011 OR8, 100 ADD16, 101 SUB16, 110 CMP8, 111 reserved
- cmd_a_i  in  16  operand A; 8-bit ops use [7:0]
- cmd_b_i  in  16  operand B; 8-bit ops use [7:0]
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_res_o  out  16  result
- rsp_flags_o  out  4  {n,z,c,o}
- alu_a_o  out  8  to ALU a_i
- alu_b_o  out  8  to ALU b_i
- alu_op_o  out  2  to ALU alu_op_i
- alu_res_i  in  8  from ALU res_o
- alu_flags_i  in  4  from ALU flags {n,z,c,o}

Behaviour:
- Interface decision: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset state: IDLE. All outputs 0 except cmd_ready_o=1. ALU ports are driven 0, op 00, in IDLE and RSP.
- States: IDLE, LO, HI, FIX, RSP.
- Command accept:
  - cmd_ready_o=1 only in IDLE.
  - On cmd_valid_i&cmd_ready_o, register op, A and B.
  - Next state: LO for valid ops; RSP for reserved 111 (res=0, flags=0).
- ALU drive: combinational from state and registered operands; ALU result and flags are captured at the clock edge ending each pass.
- LO pass: ALU gets A[7:0], B[7:0].
  - ALU op: ADD8/ADD16 -> 00; SUB8/SUB16/CMP8 -> 01; AND8 -> 10; OR8 -> 11.
  - 8-bit ops go to RSP:
    - res = {8'h00, alu_res_i}; flags = alu_flags_i.
    - CMP8: res = 16'h0000, flags from the SUB pass.
  - 16-bit ops: store lo byte and c_lo; go to HI.
- HI pass: ALU gets A[15:8], B[15:8], same op. Store h, c_hi. Go to FIX.
- FIX pass: ALU gets a=h.
  - ADD16: op 00, b={7'b0,c_lo}.
  - SUB16: op 01, b={7'b0,~c_lo}.
  - Go to RSP.
- 16-bit flags, computed in-block:
  - n = res[15]; z = (res==0).
  - c = c_hi|c_fix for ADD16; c = c_hi&c_fix for SUB16 (c=1 means no borrow).
  - o = 16-bit signed overflow from A[15], B[15], res[15], using the add or sub rule.
- Latency, acceptance edge to rsp_valid_o=1: 8-bit ops 2 cycles; 16-bit ops 4 cycles; reserved op 1 cycle.
- RSP:
  - rsp_valid_o=1; rsp_res_o/rsp_flags_o held stable until rsp_valid_o&rsp_ready_i.
  - Then return to IDLE; next command accepted in the following cycle, no combinational ready passthrough.
  - rsp_ready_i may be high before valid; response still lasts at least one cycle.
- Reset mid-operation: immediate return to IDLE; in-flight command is dropped and no response is produced.
- Inputs during non-IDLE states are ignored.

Optional Feature:
- Macro: TINY_ALU_SEQ_STATS_EN.
- Defined: adds output op_count_o [15:0].
  - Increments on each completed response handshake; saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: no port, no counter logic.

Decomposition:
- Package tiny_alu_pkg:
  - cmd op enum (3 bit)
  - ALU op constants (ADD=00, SUB=01, AND=10, OR=11)
  - flag bit indices (N=3, Z=2, C=1, O=0)
  - state enum
- Sub-module tiny_alu_flag16 (combinational): computes 16-bit {n,z,c,o} from A/B sign bits, 16-bit result, c_hi, c_fix and an is_sub flag.
- Bench instantiates tiny_alu_seq wired to tiny_alu.

Test Plan:
- ADD8 A=0x007F B=0x0001 -> res 0x0080, flags 4'b1001; rsp_valid_o 2 cycles after accept.
- SUB8 A=0x0005 B=0x0005 -> res 0x0000, flags 4'b0110; CMP8 with the same operands -> res 0x0000, flags 4'b0110.
- ADD16 A=0x00FF B=0x0001 -> res 0x0100, flags 4'b0000, latency 4; ADD16 0x7FFF+0x0001 -> res 0x8000, flags 4'b1001.
- SUB16 A=0x0000 B=0x0001 -> res 0xFFFF, flags 4'b1000; SUB16 0x1234-0x1234 -> res 0x0000, flags 4'b0110.
- Backpressure: hold rsp_ready_i=0 for 5 cycles after AND8 0x00F0&0x003C -> rsp_res_o stays 0x0030, cmd_ready_o=0; a second command is presented and is accepted only after the handshake.
- rst_ni low during HI of an ADD16 -> IDLE next cycle, no response; reserved op 111 -> res 0, flags 0, latency 1; with STATS_EN, op_count_o counts completed responses only.
